// File: rtl/letc_core_pkg.sv
// Shared core types: register index, data word and register-file init states.
package letc_core_pkg;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   typedef enum logic {
      RF_INIT,
      RF_RUN
   } rf_state_e;

   localparam int unsigned NUM_REGS = 32;
   localparam reg_idx_t    LAST_IDX = 5'd31;

endpackage

// File: rtl/letc_core_rf_read_port.sv
// One registered register-file read port with stall-hold and x0 masking.
// LETC_RF_BYPASS_EN adds write-through for sampled and held indices.
module letc_core_rf_read_port
   import letc_core_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     run,
   input  logic     stall,
   input  reg_idx_t idx,
   input  word_t    rdata,
`ifdef LETC_RF_BYPASS_EN
   input  logic     wr_en,
   input  reg_idx_t wr_idx,
   input  word_t    wr_val,
`endif
   output word_t    val
);

   word_t val_q;
   word_t sample_val;

`ifdef LETC_RF_BYPASS_EN
   reg_idx_t cap_idx_q;
   logic     hold_hit;

   // wr_en already excludes x0, so a held x0 can never be overwritten
   assign hold_hit = wr_en && (wr_idx == cap_idx_q);

   always_comb begin
      sample_val = rdata;
      if (idx == '0)
         sample_val = '0;
      else if (wr_en && (wr_idx == idx))
         sample_val = wr_val;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_idx_q <= '0;
         val_q     <= '0;
      end else if (!run) begin
         val_q <= '0;
         if (!stall)
            cap_idx_q <= idx;
      end else if (!stall) begin
         cap_idx_q <= idx;
         val_q     <= sample_val;
      end else if (hold_hit) begin
         val_q <= wr_val;
      end
   end
`else
   always_comb begin
      sample_val = rdata;
      if (idx == '0)
         sample_val = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         val_q <= '0;
      else if (!run)
         val_q <= '0;
      else if (!stall)
         val_q <= sample_val;
   end
`endif

   assign val = val_q;

endmodule

// File: rtl/letc_core_rf.sv
// Integer register file x0..x31: one write port, NUM_RD_PORTS registered read ports,
// zero-fill of x1..x31 after reset. Optional write-through: LETC_RF_BYPASS_EN.
//
// state   | meaning
// RF_INIT | writing INIT_VAL to x[cnt], one register per cycle; rf_ready=0
// RF_RUN  | init done, writeback and reads honoured; terminal until reset
module letc_core_rf
   import letc_core_pkg::*;
#(
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter word_t       INIT_VAL     = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        rf_ready,
   input  reg_idx_t                    rf_rd_idx,
   input  word_t                       rf_rd_val,
   input  logic                        rf_rd_we,
   input  logic                        rs_stall,
   input  reg_idx_t [NUM_RD_PORTS-1:0] rs_idx,
   output word_t    [NUM_RD_PORTS-1:0] rs_val
);

   rf_state_e state_q, state_d;
   reg_idx_t  cnt_q, cnt_d;
   logic      init_we;
   logic      run;
   logic      wr_en;
   word_t     mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RF_INIT;
         cnt_q   <= 5'd1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_we = 1'b0;
      case (state_q)
         RF_INIT: begin
            init_we = 1'b1;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == LAST_IDX)
               state_d = RF_RUN;
         end
         RF_RUN: ;
         default: state_d = RF_INIT;
      endcase
   end

   assign run      = (state_q == RF_RUN);
   assign rf_ready = run;
   assign wr_en    = run && rf_rd_we && (rf_rd_idx != '0);

   // x0 is never written; its slot is masked on every read
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (init_we)
            mem[cnt_q] <= INIT_VAL;
         else if (wr_en)
            mem[rf_rd_idx] <= rf_rd_val;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      letc_core_rf_read_port u_port (
         .clk    (clk),
         .rst_n  (rst_n),
         .run    (run),
         .stall  (rs_stall),
         .idx    (rs_idx[p]),
         .rdata  (mem[rs_idx[p]]),
`ifdef LETC_RF_BYPASS_EN
         .wr_en  (wr_en),
         .wr_idx (rf_rd_idx),
         .wr_val (rf_rd_val),
`endif
         .val    (rs_val[p])
      );
   end

endmodule

// File: tb/tb_letc_core_rf.sv
// Directed bench for letc_core_rf; read expectations flow through a scoreboard queue.
module tb_letc_core_rf;
   import letc_core_pkg::*;

   localparam int NP = 2;
`ifdef LETC_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic                rf_ready;
   reg_idx_t            rf_rd_idx;
   word_t               rf_rd_val;
   logic                rf_rd_we;
   logic                rs_stall;
   reg_idx_t [NP-1:0]   rs_idx;
   word_t    [NP-1:0]   rs_val;

   typedef struct {
      int    port;
      word_t exp;
      string tag;
   } sb_t;

   sb_t   sb_q[$];
   word_t ref_x[32];
   int    n_assert = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   letc_core_rf #(.NUM_RD_PORTS(NP), .INIT_VAL(32'h0000_0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rf_ready  (rf_ready),
      .rf_rd_idx (rf_rd_idx),
      .rf_rd_val (rf_rd_val),
      .rf_rd_we  (rf_rd_we),
      .rs_stall  (rs_stall),
      .rs_idx    (rs_idx),
      .rs_val    (rs_val)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(string tag, word_t obs, word_t exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(string tag, int obs, int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_rd(int p, word_t e, string tag);
      sb_q.push_back('{p, e, tag});
   endtask

   task automatic tick_check();
      sb_t e;
      tick();
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk_word(e.tag, rs_val[e.port], e.exp);
      end
   endtask

   task automatic drive_wr(reg_idx_t idx, word_t val);
      rf_rd_we  = 1'b1;
      rf_rd_idx = idx;
      rf_rd_val = val;
   endtask

   // Counts cycles until rf_ready, checking that reads stay zero meanwhile
   task automatic count_init(string tag);
      int n;
      n = 0;
      while (rf_ready !== 1'b1 && n < 100) begin
         chk_word({tag, "_rs0_zero"}, rs_val[0], 32'h0);
         chk_word({tag, "_rs1_zero"}, rs_val[1], 32'h0);
         tick();
         n++;
      end
      chk_int({tag, "_cycles"}, n, 31);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) ref_x[i] = 32'h0;
      rst_n     = 1'b0;
      rf_rd_we  = 1'b0;
      rf_rd_idx = '0;
      rf_rd_val = '0;
      rs_stall  = 1'b0;
      rs_idx[0] = 5'd5;
      rs_idx[1] = 5'd7;
      repeat (2) tick();
      chk_int("reset_ready", int'(rf_ready), 0);
      chk_word("reset_rs0", rs_val[0], 32'h0);
      rst_n = 1'b1;

      // Partial init with a write attempt at cycle 12, then reset at cycle 20
      for (int i = 1; i <= 20; i++) begin
         rf_rd_we = 1'b0;
         if (i == 12) drive_wr(5'd10, 32'hDEAD_BEEF);
         tick();
         chk_int("init_ready_low", int'(rf_ready), 0);
         chk_word("init_rs0_zero", rs_val[0], 32'h0);
      end
      rf_rd_we = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      count_init("restart");
      chk_int("ready_high", int'(rf_ready), 1);

      // Write x5, read it back; x0 write dropped
      rs_idx[0] = '0;
      rs_idx[1] = '0;
      drive_wr(5'd5, 32'hCAFE_F00D);
      tick();
      ref_x[5] = 32'hCAFE_F00D;
      rf_rd_we = 1'b0;
      rs_idx[0] = 5'd5;
      expect_rd(0, ref_x[5], "rd_x5");
      tick_check();
      drive_wr(5'd0, 32'hFFFF_FFFF);
      tick();
      rf_rd_we = 1'b0;
      rs_idx[0] = 5'd0;
      rs_idx[1] = 5'd0;
      expect_rd(0, 32'h0, "rd_x0_p0");
      expect_rd(1, 32'h0, "rd_x0_p1");
      tick_check();
      rs_idx[0] = 5'd10;
      rs_idx[1] = 5'd20;
      expect_rd(0, 32'h0, "rd_x10_cleared");
      expect_rd(1, 32'h0, "rd_x20_cleared");
      tick_check();

      // Same-cycle write and read of x7
      drive_wr(5'd7, 32'h0000_0001);
      tick();
      ref_x[7] = 32'h0000_0001;
      drive_wr(5'd7, 32'h1234_5678);
      rs_idx[0] = 5'd7;
      expect_rd(0, BYP ? 32'h1234_5678 : 32'h0000_0001, "rw_x7_same");
      tick_check();
      ref_x[7] = 32'h1234_5678;
      rf_rd_we = 1'b0;
      expect_rd(0, ref_x[7], "rd_x7_after");
      tick_check();

      // Stall-hold on x3 while x3 is overwritten
      drive_wr(5'd3, 32'h0000_00AA);
      tick();
      ref_x[3] = 32'h0000_00AA;
      drive_wr(5'd9, 32'h0000_0099);
      tick();
      ref_x[9] = 32'h0000_0099;
      rf_rd_we = 1'b0;
      rs_idx[0] = 5'd3;
      rs_idx[1] = 5'd3;
      expect_rd(0, ref_x[3], "pre_stall_p0");
      expect_rd(1, ref_x[3], "pre_stall_p1");
      tick_check();
      rs_stall = 1'b1;
      rs_idx[0] = 5'd9;
      rs_idx[1] = 5'd0;
      for (int i = 0; i < 4; i++) begin
         rf_rd_we = 1'b0;
         if (i == 0) drive_wr(5'd3, 32'h0000_00BB);
         expect_rd(0, BYP ? 32'h0000_00BB : 32'h0000_00AA, "stall_hold_p0");
         expect_rd(1, BYP ? 32'h0000_00BB : 32'h0000_00AA, "stall_hold_p1");
         tick_check();
      end
      ref_x[3] = 32'h0000_00BB;
      rf_rd_we = 1'b0;
      rs_stall = 1'b0;
      rs_idx[0] = 5'd9;
      rs_idx[1] = 5'd3;
      expect_rd(0, ref_x[9], "unstall_x9");
      expect_rd(1, ref_x[3], "unstall_x3");
      tick_check();

      // Two ports, x31 and x1, while x1 is written
      drive_wr(5'd31, 32'h3131_3131);
      tick();
      ref_x[31] = 32'h3131_3131;
      drive_wr(5'd1, 32'h55AA_55AA);
      rs_idx[0] = 5'd31;
      rs_idx[1] = 5'd1;
      expect_rd(0, ref_x[31], "dual_x31");
      expect_rd(1, BYP ? 32'h55AA_55AA : ref_x[1], "dual_x1_wr");
      tick_check();
      ref_x[1] = 32'h55AA_55AA;
      drive_wr(5'd1, 32'h0F0F_0F0F);
      rs_idx[0] = 5'd1;
      expect_rd(0, BYP ? 32'h0F0F_0F0F : ref_x[1], "both_x1_p0");
      expect_rd(1, BYP ? 32'h0F0F_0F0F : ref_x[1], "both_x1_p1");
      tick_check();
      ref_x[1] = 32'h0F0F_0F0F;
      rf_rd_we = 1'b0;
      rs_idx[1] = 5'd31;
      expect_rd(0, ref_x[1], "final_x1");
      expect_rd(1, ref_x[31], "final_x31");
      tick_check();
      chk_int("ready_stays", int'(rf_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
